// File: rtl/ring_pkg.sv
// Shared sizing helpers and small enums for the ring FIFO pointer/level logic.
// Pure package: no storage, no latency.
// Backpressure handling lives in ring_fifo; nothing here affects flow control.
package ring_pkg;

  // Pointer width: enough bits to index DEPTH entries.
  // At least one bit, so that the degenerate clog2 case still yields a legal vector.
  function automatic int ptr_w(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

  // Level width: must represent 0..DEPTH inclusive, hence the extra bit.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy change applied by the level counter in one cycle.
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,  // no handshake, or push and pop together
    LVL_INC  = 2'd1,  // push only
    LVL_DEC  = 2'd2   // pop only
  } lvl_op_e;

endpackage

// File: rtl/ring_ptr.sv
// Increment-only modulo-DEPTH pointer for one end of the ring FIFO.
// Latency: ptr updates on the clk edge where adv is sampled high.
// Backpressure: none; the caller qualifies adv with its own handshake.
//
// Ports:
//   clk   - clock
//   rst_n - synchronous reset, active high (asserted = 1); ptr -> 0
//   clr   - synchronous clear, below reset and above adv; ptr -> 0
//   adv   - advance by one; DEPTH-1 wraps to 0
//   ptr   - current pointer value, 0..DEPTH-1
module ring_ptr
  import ring_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     adv,
  output logic [ptr_w(DEPTH)-1:0]  ptr
);

  localparam int PW = ptr_w(DEPTH);
  // Explicit wrap compare, so DEPTH need not be a power of two.
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (adv) begin
      if (ptr == PTR_LAST) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ring_fifo.sv
// Circular FIFO with valid/ready on both ends and first-word fall-through reads.
// Latency: a write accepted at edge N shows up on rd_data with rd_valid in cycle N+1.
// Backpressure: wr_ready = !full and rd_valid = !empty, both decoded from the registered level only.
//
// Ports:
//   clk      - clock; every state update happens on its rising edge
//   rst_n    - synchronous reset, active high (asserted = 1); clears pointers and level
//   flush    - synchronous clear of pointers and level; storage is not touched
//   wr_valid - producer offers wr_data
//   wr_ready - FIFO can accept a write this cycle
//   wr_data  - write data
//   rd_valid - rd_data holds the head entry
//   rd_ready - consumer takes the head entry this cycle
//   rd_data  - head entry; meaningless while rd_valid = 0
//   level    - occupancy, 0..DEPTH
//   full     - level == DEPTH
//   empty    - level == 0
module ring_fifo
  import ring_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [lvl_w(DEPTH)-1:0]  level,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic    push;
  logic    pop;
  logic    clr;
  logic    wr_en;
  lvl_op_e lvl_op;

  // Flags come straight from the level register, which keeps rd_ready off
  // the wr_ready path and wr_valid off the rd_valid path.
  assign full     = (level == LVL_MAX);
  assign empty    = (level == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;
  assign clr  = flush;

  // A handshake that coincides with reset or flush is dropped, so the
  // write into storage is suppressed as well.
  assign wr_en = push && !rst_n && !flush;

  ring_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (push),
    .ptr   (wr_ptr)
  );

  ring_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is never reset; only the pointers/level say what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Fall-through read: the head entry is presented combinationally.
  assign rd_data = mem[rd_ptr];

  always_comb begin
    lvl_op = LVL_HOLD;
    if (push && !pop) begin
      lvl_op = LVL_INC;
    end else if (pop && !push) begin
      lvl_op = LVL_DEC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      level <= '0;
    end else if (flush) begin
      level <= '0;
    end else begin
      case (lvl_op)
        LVL_INC: level <= level + LW'(1);
        LVL_DEC: level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
